// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start, LSB-first data, parity, stop; registers reduction flags of each accepted word.
// Optional TX_ERR_INJECT_EN adds err_inject, which inverts the sent parity bit of one frame.
`timescale 1ns/1ps
module parity_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
`ifdef TX_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    output logic              din_ready,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              and_flag,
    output logic              or_flag,
    output logic              xor_flag
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // state | meaning: IDLE wait for word | START tx=0 | DATA shift bits | PARITY parity bit | STOP tx=1
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              and_q, and_d;
    logic              or_q, or_d;
    logic              xor_q, xor_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              inj;
    logic              last_tick;

`ifdef TX_ERR_INJECT_EN
    assign inj = err_inject;
`else
    assign inj = 1'b0;
`endif

    assign last_tick = (baud_q == 8'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 8'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        and_d   = and_q;
        or_d    = or_q;
        xor_d   = xor_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = 8'd0;
                if (din_valid) begin
                    shift_d = din;
                    and_d   = &din;
                    or_d    = |din;
                    xor_d   = ^din;
                    par_d   = (^din) ^ (ODD_PARITY != 0) ^ inj;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last_tick) begin
                    baud_d  = 8'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (last_tick) begin
                    baud_d = 8'd0;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = S_PARITY;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (last_tick) begin
                    baud_d  = 8'd0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (last_tick) begin
                    baud_d  = 8'd0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                baud_d  = 8'd0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are derived from next-state values so they register in step with the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= 8'd0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            and_q   <= 1'b0;
            or_q    <= 1'b0;
            xor_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            and_q   <= and_d;
            or_q    <= or_d;
            xor_q   <= xor_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign din_ready = ready_q;
    assign and_flag  = and_q;
    assign or_flag   = or_q;
    assign xor_flag  = xor_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Bench for parity_serial_tx: unit 1 is 4-bit/4 clocks/even parity, unit 2 is 4-bit/1 clock/odd parity.
`timescale 1ns/1ps
module tb_parity_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din1 = 4'd0, din2 = 4'd0;
    logic       v1 = 1'b0, v2 = 1'b0;
    logic       err1 = 1'b0, err2 = 1'b0;
    logic       tx1, rdy1, busy1, done1, and1, or1, xor1;
    logic       tx2, rdy2, busy2, done2, and2, or2, xor2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .ODD_PARITY(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(v1),
`ifdef TX_ERR_INJECT_EN
        .err_inject(err1),
`endif
        .din_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1),
        .and_flag(and1), .or_flag(or1), .xor_flag(xor1)
    );

    parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .ODD_PARITY(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .din_valid(v2),
`ifdef TX_ERR_INJECT_EN
        .err_inject(err2),
`endif
        .din_ready(rdy2), .tx(tx2), .busy(busy2), .done(done2),
        .and_flag(and2), .or_flag(or2), .xor_flag(xor2)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sends one word and checks the whole frame cycle by cycle; called on a negedge with the unit idle.
    // mode 0: drop valid after accept; 1: keep valid high with junk din; 2: toggle valid/din randomly.
    task automatic run_frame(input int sel, input logic [3:0] word, input logic err, input int mode);
        int   c, len, ones;
        logic frame [0:6];
        logic e_and, e_or, e_xor;
        logic o_tx, o_busy, o_done, o_rdy, o_and, o_or, o_xor;
        c = (sel == 0) ? 4 : 1;
        len = 7 * c;
        ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(word[i]);
        e_and = (ones == 4);
        e_or  = (ones > 0);
        e_xor = (ones % 2 == 1);
        frame[0] = 1'b0;
        for (int i = 0; i < 4; i++) frame[1+i] = word[i];
        frame[5] = e_xor ^ (sel == 1) ^ err;
        frame[6] = 1'b1;

        if (sel == 0) begin din1 = word; v1 = 1'b1; err1 = err; end
        else          begin din2 = word; v2 = 1'b1; err2 = err; end
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0 && mode == 0) begin
                if (sel == 0) v1 = 1'b0; else v2 = 1'b0;
            end
            if (mode == 1) begin
                if (sel == 0) din1 = 4'($urandom); else din2 = 4'($urandom);
            end
            if (mode == 2) begin
                if (sel == 0) begin din1 = 4'($urandom); v1 = (k != len-1) && $urandom_range(0,1) == 1; end
                else          begin din2 = 4'($urandom); v2 = (k != len-1) && $urandom_range(0,1) == 1; end
            end
            o_tx   = (sel == 0) ? tx1 : tx2;
            o_busy = (sel == 0) ? busy1 : busy2;
            o_done = (sel == 0) ? done1 : done2;
            o_rdy  = (sel == 0) ? rdy1 : rdy2;
            checks++;
            if (o_tx !== frame[k / c]) begin
                errors++;
                $display("FAIL tx_bit unit%0d word=%b cycle %0d: got %b expected %b", sel+1, word, k, o_tx, frame[k/c]);
            end
            checks++;
            if ({o_busy, o_done, o_rdy} !== 3'b100) begin
                errors++;
                $display("FAIL in_frame_status unit%0d cycle %0d: busy/done/ready got %b expected 100", sel+1, k, {o_busy, o_done, o_rdy});
            end
            if (k == 0 || k == len-1) begin
                o_and = (sel == 0) ? and1 : and2;
                o_or  = (sel == 0) ? or1 : or2;
                o_xor = (sel == 0) ? xor1 : xor2;
                checks++;
                if ({o_and, o_or, o_xor} !== {e_and, e_or, e_xor}) begin
                    errors++;
                    $display("FAIL flags unit%0d word=%b cycle %0d: and/or/xor got %b expected %b", sel+1, word, k, {o_and, o_or, o_xor}, {e_and, e_or, e_xor});
                end
            end
        end
        @(negedge clk);
        o_tx   = (sel == 0) ? tx1 : tx2;
        o_busy = (sel == 0) ? busy1 : busy2;
        o_done = (sel == 0) ? done1 : done2;
        o_rdy  = (sel == 0) ? rdy1 : rdy2;
        checks++;
        if ({o_tx, o_busy, o_done, o_rdy} !== 4'b1011) begin
            errors++;
            $display("FAIL done_cycle unit%0d word=%b: tx/busy/done/ready got %b expected 1011", sel+1, word, {o_tx, o_busy, o_done, o_rdy});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({tx1, rdy1, busy1, done1, and1, or1, xor1} !== 7'b1100000) begin
                errors++;
                $display("FAIL reset_idle unit1 cycle %0d: got %b expected 1100000", k, {tx1, rdy1, busy1, done1, and1, or1, xor1});
            end
            checks++;
            if ({tx2, rdy2, busy2, done2, and2, or2, xor2} !== 7'b1100000) begin
                errors++;
                $display("FAIL reset_idle unit2 cycle %0d: got %b expected 1100000", k, {tx2, rdy2, busy2, done2, and2, or2, xor2});
            end
        end
    endtask

    task automatic test_basic();
        run_frame(0, 4'b0011, 1'b0, 0);
    endtask

    task automatic test_flags();
        run_frame(0, 4'b0001, 1'b0, 0);
        run_frame(0, 4'b1111, 1'b0, 0);
        run_frame(0, 4'b0000, 1'b0, 0);
        run_frame(1, 4'b0000, 1'b0, 0);
        run_frame(1, 4'b1111, 1'b0, 0);
        run_frame(1, 4'b0111, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_frame(0, 4'b1010, 1'b0, 1);
        run_frame(0, 4'b0101, 1'b0, 2);
        run_frame(1, 4'b1100, 1'b0, 1);
        run_frame(1, 4'b1000, 1'b0, 0);
    endtask

    task automatic test_mid_reset();
        din1 = 4'b1011;
        v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_precondition: busy got %b expected 1", busy1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx1, busy1, rdy1, and1, or1, xor1} !== 6'b101000) begin
            errors++;
            $display("FAIL async_reset: tx/busy/ready/and/or/xor got %b expected 101000", {tx1, busy1, rdy1, and1, or1, xor1});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({done1, tx1} !== 2'b01) begin
                errors++;
                $display("FAIL reset_no_done cycle %0d: done/tx got %b expected 01", k, {done1, tx1});
            end
        end
        rst_n = 1'b1;
        run_frame(0, 4'b0110, 1'b0, 0);
    endtask

    task automatic test_err_inject();
`ifdef TX_ERR_INJECT_EN
        run_frame(0, 4'b0011, 1'b1, 0);
        run_frame(0, 4'b0011, 1'b0, 0);
        run_frame(1, 4'b0001, 1'b1, 0);
        run_frame(1, 4'b0001, 1'b0, 0);
`endif
        err1 = 1'b0;
        err2 = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int   sel;
            logic err;
            sel = $urandom_range(0, 1);
`ifdef TX_ERR_INJECT_EN
            err = ($urandom_range(0, 3) == 0);
`else
            err = 1'b0;
`endif
            run_frame(sel, 4'($urandom), err, (n % 3 == 1) ? 2 : 0);
        end
        err1 = 1'b0;
        err2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_back_to_back();
        test_mid_reset();
        test_err_inject();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
